// File: rtl/sdr_pkg.sv
// Types and default sizing shared by the SDR bridge arbiter and its round-robin picker.
package sdr_pkg;

    localparam int DEFAULT_DATA_W      = 2048;
    localparam int DEFAULT_MAX_NELEMS  = 64;
    localparam int DEFAULT_TIMEOUT_CYC = 1048576;
    localparam int TIMEOUT_CNT_W       = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] baseaddr;
        logic [29:0] nelems;
    } cmd_t;

    // Sticks at all-ones instead of wrapping.
    function automatic logic [TIMEOUT_CNT_W-1:0] sat_inc(input logic [TIMEOUT_CNT_W-1:0] v);
        return (&v) ? v : v + TIMEOUT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sdr_arbiter_rr_picker.sv
// Combinational round-robin selection: the first valid requester at or after i_ptr wins.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % NREQ);
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdr_arbiter.sv
// Round-robin arbiter that serialises requester commands onto a single SDR read/write bridge,
// with zero/oversize short-circuit, per-transaction timeout and one completion pulse per grant.
module sdr_arbiter
    import sdr_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MAX_NELEMS  = DEFAULT_MAX_NELEMS,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                   sdr_clk,
    input  logic                   sdr_reset_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*32-1:0]     req_baseaddr,
    input  logic [NREQ*30-1:0]     req_nelems,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_done,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   sdr_readstart,
    output logic                   sdr_writestart,
    output logic [31:0]            sdr_baseaddr,
    output logic [29:0]            sdr_nelems,
    output logic [DATA_W-1:0]      sdr_writedata,
    input  logic                   sdr_readend,
    input  logic                   sdr_writeend,
    input  logic [DATA_W-1:0]      sdr_readdata,
    output logic                   busy,
    output state_e                 o_dbg_state
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a requester raises req_valid with a stable command; the arbiter answers with a
    // single-cycle req_ready in the same cycle it latches the command, after which the requester
    // may drop or change anything. Each accepted command produces exactly one rsp_done pulse
    // (qualified by rsp_err) unless reset intervenes.

    state_e                   r_state, w_next;
    cmd_t                     r_cmd, w_sel;
    logic [DATA_W-1:0]        r_wdata, r_rdata;
    logic [IDX_W-1:0]         r_owner, r_rr_ptr, w_idx;
    logic [TIMEOUT_CNT_W-1:0] r_cnt, w_cnt_inc;
    logic [NREQ-1:0]          w_grant;
    logic                     r_err, w_err_load, w_err_val;
    logic                     w_any, w_match, w_timeout;

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel.write    = req_write[w_idx];
        w_sel.baseaddr = req_baseaddr[int'(w_idx)*32 +: 32];
        w_sel.nelems   = req_nelems[int'(w_idx)*30 +: 30];
    end

    assign w_match   = r_cmd.write ? sdr_writeend : sdr_readend;
    assign w_cnt_inc = sat_inc(r_cnt);
    // Fires on the WAIT cycle whose increment lands on TIMEOUT_CYC-1, so rsp_done follows the
    // start pulse by exactly TIMEOUT_CYC cycles; a matching end on that cycle takes priority.
    assign w_timeout = (w_cnt_inc >= TIMEOUT_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
        if (!sdr_reset_n) r_state <= IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        req_ready      = '0;
        rsp_done       = '0;
        sdr_readstart  = 1'b0;
        sdr_writestart = 1'b0;
        w_err_load     = 1'b0;
        w_err_val      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready = w_grant;
                    if (w_sel.nelems == '0) begin
                        w_next     = RESP;
                        w_err_load = 1'b1;
                    end else if (w_sel.nelems > 30'(MAX_NELEMS)) begin
                        w_next     = RESP;
                        w_err_load = 1'b1;
                        w_err_val  = 1'b1;
                    end else begin
                        w_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                sdr_readstart  = !r_cmd.write;
                sdr_writestart = r_cmd.write;
                w_next         = WAIT;
            end
            WAIT: begin
                if (w_match) begin
                    w_next     = RESP;
                    w_err_load = 1'b1;
                end else if (w_timeout) begin
                    w_next     = RESP;
                    w_err_load = 1'b1;
                    w_err_val  = 1'b1;
                end
            end
            RESP: begin
                rsp_done[r_owner] = 1'b1;
                w_next            = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
        if (!sdr_reset_n) begin
            r_cmd    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_cmd   <= w_sel;
                r_wdata <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                r_owner <= w_idx;
            end
            if (r_state == ISSUE)     r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= w_cnt_inc;
            if (w_err_load) r_err <= w_err_val;
            if (r_state == WAIT && !r_cmd.write && sdr_readend) r_rdata <= sdr_readdata;
            if (r_state == RESP)
                r_rr_ptr <= (int'(r_owner) == NREQ - 1) ? '0 : r_owner + IDX_W'(1);
        end
    end

    assign rsp_err       = (r_state == RESP) && r_err;
    assign rsp_rdata     = r_rdata;
    assign sdr_baseaddr  = r_cmd.baseaddr;
    assign sdr_nelems    = r_cmd.nelems;
    assign sdr_writedata = r_wdata;
    assign busy          = (r_state != IDLE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sdr_arbiter.sv
// Self-checking bench for sdr_arbiter: directed scenarios plus randomized commands against a
// transaction-level model (round-robin pick, expected error, expected latency, expected read data).
module tb_sdr_arbiter;
  import sdr_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 64;
  localparam int MAXN = 64;
  localparam int TO   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic sdr_clk = 1'b0;
  logic sdr_reset_n = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_write = '0;
  logic [NREQ*32-1:0] req_baseaddr = '0;
  logic [NREQ*30-1:0] req_nelems = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0] req_ready, rsp_done;
  logic rsp_err, sdr_readstart, sdr_writestart, busy;
  logic [DW-1:0] rsp_rdata, sdr_writedata;
  logic [DW-1:0] sdr_readdata = '0;
  logic [31:0] sdr_baseaddr;
  logic [29:0] sdr_nelems;
  logic sdr_readend = 1'b0, sdr_writeend = 1'b0;
  state_e dbg_state;

  sdr_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_NELEMS(MAXN), .TIMEOUT_CYC(TO)) dut (
    .sdr_clk(sdr_clk), .sdr_reset_n(sdr_reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_baseaddr(req_baseaddr),
    .req_nelems(req_nelems), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
    .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
    .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend), .sdr_readdata(sdr_readdata),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  always #5 sdr_clk = ~sdr_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- event monitor (samples on the falling edge) ----------------
  int cyc = 0, n_ready = 0, n_start = 0, n_done = 0;
  int ready_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [NREQ-1:0] ready_vec, done_vec;
  logic start_rd, start_wr, done_err;
  logic [31:0] st_addr;
  logic [29:0] st_n;
  logic [DW-1:0] st_wd, done_rdata;
  logic [NREQ-1:0] gq[$];
  int gcq[$];
  logic dq_err[$];

  always @(negedge sdr_clk) begin
    cyc++;
    if (req_ready != '0) begin
      n_ready++; ready_cyc = cyc; ready_vec = req_ready;
      gq.push_back(req_ready); gcq.push_back(cyc);
    end
    if (sdr_readstart || sdr_writestart) begin
      n_start++; start_cyc = cyc; start_rd = sdr_readstart; start_wr = sdr_writestart;
      st_addr = sdr_baseaddr; st_n = sdr_nelems; st_wd = sdr_writedata;
    end
    if (rsp_done != '0) begin
      n_done++; done_cyc = cyc; done_vec = rsp_done; done_err = rsp_err; done_rdata = rsp_rdata;
      dq_err.push_back(rsp_err);
    end
  end

  // ---------------- reference model ----------------
  int m_ptr = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [NREQ-1:0] exp_q[$];

  function automatic int model_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sdr_clk);
    #1;
  endtask

  task automatic issue(input int who, input logic wr, input logic [31:0] a, input logic [29:0] n,
                       input logic [DW-1:0] wd, output bit ok);
    int base;
    base = n_ready;
    ok = 1'b0;
    req_write[who] = wr;
    req_baseaddr[who*32 +: 32] = a;
    req_nelems[who*30 +: 30] = n;
    req_wdata[who*DW +: DW] = wd;
    req_valid[who] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = (n_ready != base);
    end
    req_valid[who] = 1'b0;
    req_write[who] = ~wr;
    req_baseaddr[who*32 +: 32] = $urandom;
    req_nelems[who*30 +: 30] = 30'($urandom);
    req_wdata[who*DW +: DW] = {$urandom, $urandom};
  endtask

  task automatic wait_start(output bit ok);
    int base;
    base = n_start;
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      step();
      ok = (n_start != base);
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int base;
    base = n_done;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = (n_done != base);
    end
  endtask

  // Pulses an end strobe 'after' cycles past the start cycle; returns the cycle it was driven in.
  task automatic bridge_end(input logic rd, input int after, input logic [DW-1:0] data, output int end_c);
    repeat (after - 1) step();
    sdr_readend = rd;
    sdr_writeend = !rd;
    sdr_readdata = data;
    end_c = cyc + 1;
    step();
    sdr_readend = 1'b0;
    sdr_writeend = 1'b0;
    sdr_readdata = {$urandom, $urandom};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 sdr_reset_n = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (req_ready !== '0 || rsp_done !== '0) begin errors++; $display("FAIL reset_pulses: ready %b done %b exp 0", req_ready, rsp_done); end
    checks++; if (sdr_readstart !== 1'b0 || sdr_writestart !== 1'b0) begin errors++; $display("FAIL reset_start: rd %b wr %b exp 0", sdr_readstart, sdr_writestart); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", rsp_err); end
    checks++; if (sdr_baseaddr !== '0 || sdr_nelems !== '0) begin errors++; $display("FAIL reset_cmd: addr %h n %h exp 0", sdr_baseaddr, sdr_nelems); end
    checks++; if (sdr_writedata !== '0 || rsp_rdata !== '0) begin errors++; $display("FAIL reset_data: wd %h rd %h exp 0", sdr_writedata, rsp_rdata); end
    sdr_reset_n = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_read();
    bit ok;
    int end_c;
    logic [DW-1:0] d;
    d = 64'hDEAD_BEEF_0BAD_F00D;
    issue(0, 1'b0, 32'h0, 30'd15, '0, ok);
    checks++; if (!ok || ready_vec !== onehot(model_pick(m_ptr, 2'b01))) begin errors++; $display("FAIL sr_ready: ok %0d got %b exp %b", ok, ready_vec, onehot(0)); end
    wait_start(ok);
    checks++; if (!ok || start_cyc != ready_cyc + 1 || start_rd !== 1'b1 || start_wr !== 1'b0) begin errors++; $display("FAIL sr_start: ok %0d cyc %0d exp %0d rd %b wr %b", ok, start_cyc, ready_cyc + 1, start_rd, start_wr); end
    checks++; if (st_addr !== 32'h0 || st_n !== 30'd15) begin errors++; $display("FAIL sr_cmd: addr %h n %0d exp 0 15", st_addr, st_n); end
    bridge_end(1'b1, 10, d, end_c);
    wait_done(10, ok);
    checks++; if (!ok || done_cyc != end_c + 1) begin errors++; $display("FAIL sr_done_lat: ok %0d cyc %0d exp %0d", ok, done_cyc, end_c + 1); end
    checks++; if (done_vec !== 2'b01 || done_err !== 1'b0) begin errors++; $display("FAIL sr_done: vec %b err %b exp 01 0", done_vec, done_err); end
    checks++; if (done_rdata !== d) begin errors++; $display("FAIL sr_rdata: got %h exp %h", done_rdata, d); end
    m_rdata = d;
    m_ptr = 1;
  endtask

  task automatic test_zero_oversize();
    bit ok;
    int sbase;
    logic [29:0] ns[2];
    ns[0] = 30'd0;
    ns[1] = 30'(MAXN + 1);
    for (int k = 0; k < 2; k++) begin
      sbase = n_start;
      issue(1, 1'b1, 32'h1000, ns[k], 64'h1234, ok);
      wait_done(10, ok);
      checks++; if (!ok || done_cyc != ready_cyc + 1 || done_vec !== 2'b10) begin errors++; $display("FAIL zo%0d_done: ok %0d cyc %0d exp %0d vec %b", k, ok, done_cyc, ready_cyc + 1, done_vec); end
      checks++; if (done_err !== (ns[k] > 30'(MAXN))) begin errors++; $display("FAIL zo%0d_err: got %b exp %b", k, done_err, ns[k] > 30'(MAXN)); end
      checks++; if (n_start != sbase) begin errors++; $display("FAIL zo%0d_nostart: starts %0d exp %0d", k, n_start, sbase); end
      checks++; if (done_rdata !== m_rdata) begin errors++; $display("FAIL zo%0d_rdata: got %h exp %h", k, done_rdata, m_rdata); end
      m_ptr = 0;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int end_c;
    logic [DW-1:0] d;
    issue(0, 1'b0, 32'h40, 30'd8, '0, ok);
    wait_start(ok);
    wait_done(30, ok);
    checks++; if (!ok || done_cyc != start_cyc + TO) begin errors++; $display("FAIL to_lat: ok %0d cyc %0d exp %0d", ok, done_cyc, start_cyc + TO); end
    checks++; if (done_err !== 1'b1 || done_rdata !== m_rdata) begin errors++; $display("FAIL to_err: err %b rd %h exp 1 %h", done_err, done_rdata, m_rdata); end
    m_ptr = 1;
    d = {$urandom, $urandom};
    issue(1, 1'b0, 32'h80, 30'd8, '0, ok);
    wait_start(ok);
    bridge_end(1'b1, TO - 1, d, end_c);
    wait_done(10, ok);
    checks++; if (!ok || done_cyc != start_cyc + TO) begin errors++; $display("FAIL to_edge_lat: ok %0d cyc %0d exp %0d", ok, done_cyc, start_cyc + TO); end
    checks++; if (done_err !== 1'b0 || done_vec !== 2'b10) begin errors++; $display("FAIL to_edge_err: err %b vec %b exp 0 10", done_err, done_vec); end
    checks++; if (done_rdata !== d) begin errors++; $display("FAIL to_edge_rdata: got %h exp %h", done_rdata, d); end
    m_rdata = d;
    m_ptr = 0;
  endtask

  task automatic test_wrong_end();
    bit ok;
    int end_c, dbase;
    logic [DW-1:0] wd;
    wd = {$urandom, $urandom};
    issue(0, 1'b1, 32'hC0, 30'd4, wd, ok);
    wait_start(ok);
    checks++; if (!ok || start_wr !== 1'b1 || st_wd !== wd) begin errors++; $display("FAIL we_start: ok %0d wr %b wd %h exp 1 %h", ok, start_wr, st_wd, wd); end
    dbase = n_done;
    bridge_end(1'b1, 3, {$urandom, $urandom}, end_c);
    step();
    checks++; if (n_done != dbase || busy !== 1'b1) begin errors++; $display("FAIL we_ignored: dones %0d exp %0d busy %b", n_done, dbase, busy); end
    bridge_end(1'b0, 3, {$urandom, $urandom}, end_c);
    wait_done(10, ok);
    checks++; if (!ok || done_cyc != end_c + 1 || done_err !== 1'b0) begin errors++; $display("FAIL we_done: ok %0d cyc %0d exp %0d err %b", ok, done_cyc, end_c + 1, done_err); end
    checks++; if (done_rdata !== m_rdata) begin errors++; $display("FAIL we_rdata: got %h exp %h", done_rdata, m_rdata); end
    checks++; if (sdr_writedata !== wd) begin errors++; $display("FAIL we_hold: got %h exp %h", sdr_writedata, wd); end
    m_ptr = 1;
  endtask

  task automatic test_random();
    bit ok;
    int who, dly, end_c, sbase;
    logic wr;
    logic [31:0] a;
    logic [29:0] n;
    logic [DW-1:0] wd, d;
    logic exp_err;
    for (int t = 0; t < 10; t++) begin
      who = $urandom_range(0, NREQ - 1);
      wr = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       n = 30'd0;
        1:       n = 30'($urandom_range(MAXN + 1, MAXN + 40));
        default: n = 30'($urandom_range(1, MAXN));
      endcase
      wd = {$urandom, $urandom};
      d = {$urandom, $urandom};
      dly = $urandom_range(1, 8);
      sbase = n_start;
      issue(who, wr, a, n, wd, ok);
      checks++; if (!ok || ready_vec !== onehot(model_pick(m_ptr, onehot(who)))) begin errors++; $display("FAIL rnd%0d_ready: ok %0d got %b exp %b", t, ok, ready_vec, onehot(who)); end
      if (n == 0 || n > 30'(MAXN)) begin
        exp_err = (n > 30'(MAXN));
        wait_done(10, ok);
        checks++; if (!ok || done_cyc != ready_cyc + 1 || n_start != sbase) begin errors++; $display("FAIL rnd%0d_skip: ok %0d cyc %0d exp %0d starts %0d exp %0d", t, ok, done_cyc, ready_cyc + 1, n_start, sbase); end
      end else begin
        exp_err = 1'b0;
        wait_start(ok);
        checks++; if (!ok || start_cyc != ready_cyc + 1 || start_wr !== wr || start_rd !== !wr) begin errors++; $display("FAIL rnd%0d_start: ok %0d cyc %0d exp %0d wr %b exp %b", t, ok, start_cyc, ready_cyc + 1, start_wr, wr); end
        checks++; if (st_addr !== a || st_n !== n || (wr && st_wd !== wd)) begin errors++; $display("FAIL rnd%0d_cmd: addr %h n %0d wd %h exp %h %0d %h", t, st_addr, st_n, st_wd, a, n, wd); end
        bridge_end(!wr, dly, d, end_c);
        wait_done(10, ok);
        checks++; if (!ok || done_cyc != end_c + 1) begin errors++; $display("FAIL rnd%0d_lat: ok %0d cyc %0d exp %0d", t, ok, done_cyc, end_c + 1); end
        if (!wr) m_rdata = d;
      end
      checks++; if (done_vec !== onehot(who) || done_err !== exp_err || done_rdata !== m_rdata) begin errors++; $display("FAIL rnd%0d_rsp: vec %b err %b rd %h exp %b %b %h", t, done_vec, done_err, done_rdata, onehot(who), exp_err, m_rdata); end
      m_ptr = (who + 1) % NREQ;
    end
  endtask

  task automatic test_contention();
    int base, w;
    bit ok;
    gq.delete(); gcq.delete(); dq_err.delete(); exp_q.delete();
    req_write = 2'b00;
    req_nelems[0 +: 30] = 30'd0;
    req_nelems[30 +: 30] = 30'(MAXN + 1);
    base = n_ready;
    req_valid = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = (n_ready - base >= 6);
    end
    req_valid = 2'b00;
    repeat (3) step();
    checks++; if (!ok || gq.size() < 6 || dq_err.size() < 6) begin errors++; $display("FAIL ct_count: grants %0d dones %0d exp 6", gq.size(), dq_err.size()); end
    for (int g = 0; g < 6; g++) begin
      w = model_pick(m_ptr, 2'b11);
      exp_q.push_back(onehot(w));
      m_ptr = (w + 1) % NREQ;
    end
    for (int g = 0; g < 6 && g < gq.size() && g < dq_err.size(); g++) begin
      checks++; if (gq[g] !== exp_q[g]) begin errors++; $display("FAIL ct_grant%0d: got %b exp %b", g, gq[g], exp_q[g]); end
      checks++; if (dq_err[g] !== exp_q[g][1]) begin errors++; $display("FAIL ct_err%0d: got %b exp %b", g, dq_err[g], exp_q[g][1]); end
      if (g > 0) begin
        checks++; if (gcq[g] - gcq[g-1] != 2) begin errors++; $display("FAIL ct_gap%0d: got %0d exp 2", g, gcq[g] - gcq[g-1]); end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int end_c, dbase;
    issue(model_pick(m_ptr, 2'b11), 1'b0, 32'hABC0, 30'd4, '0, ok);
    wait_start(ok);
    step(); step();
    dbase = n_done;
    sdr_reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL rw_busy: got %b exp 0", busy); end
    checks++; if (sdr_baseaddr !== '0 || sdr_nelems !== '0 || sdr_writedata !== '0) begin errors++; $display("FAIL rw_cmd: addr %h n %h wd %h exp 0", sdr_baseaddr, sdr_nelems, sdr_writedata); end
    checks++; if (rsp_rdata !== '0 || rsp_err !== 1'b0 || rsp_done !== '0) begin errors++; $display("FAIL rw_rsp: rd %h err %b done %b exp 0", rsp_rdata, rsp_err, rsp_done); end
    step();
    sdr_reset_n = 1'b1;
    m_ptr = 0;
    m_rdata = '0;
    bridge_end(1'b1, 1, {$urandom, $urandom}, end_c);
    repeat (20) step();
    checks++; if (n_done != dbase || busy !== 1'b0) begin errors++; $display("FAIL rw_silent: dones %0d exp %0d busy %b", n_done, dbase, busy); end
    checks++; if (rsp_rdata !== m_rdata) begin errors++; $display("FAIL rw_rdata: got %h exp %h", rsp_rdata, m_rdata); end
    issue(1, 1'b1, 32'h10, 30'd0, '0, ok);
    checks++; if (!ok || ready_vec !== onehot(model_pick(m_ptr, 2'b10))) begin errors++; $display("FAIL rw_regrant: ok %0d got %b exp 10", ok, ready_vec); end
    wait_done(10, ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_zero_oversize();
    test_timeout();
    test_wrong_end();
    test_random();
    test_contention();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_arbiter.md
SDR_ARBITER -- requirements
Module: sdr_arbiter

Interface
REQ-001 Parameters: NREQ, 2, number of requesters; DATA_W, 2048, bridge data width; MAX_NELEMS, 64, largest legal burst in 32-bit words; TIMEOUT_CYC, 1048576, cycles to wait for an end pulse.
REQ-002 Ports: sdr_clk  in  1  sole clock; reset is asynchronous and active-low; sdr_reset_n  in  1  async active-low reset.
REQ-003 req_valid  in  NREQ  per-requester command pending; req_write  in  NREQ  1=write, 0=read.
REQ-004 req_baseaddr  in  NREQ*32  byte base address; req_nelems  in  NREQ*30  word count; req_wdata  in  NREQ*DATA_W  write payload.
REQ-005 req_ready  out  NREQ  one-cycle accept pulse; rsp_done  out  NREQ  one-cycle completion pulse; rsp_err  out  1  qualifies rsp_done; rsp_rdata  out  DATA_W  read result.
REQ-006 sdr_readstart / sdr_writestart  out  1  bridge start pulses; sdr_baseaddr  out  32; sdr_nelems  out  30; sdr_writedata  out  DATA_W.
REQ-007 sdr_readend / sdr_writeend  in  1  bridge completion pulses; sdr_readdata  in  DATA_W  bridge read data; busy  out  1  transaction in flight.

Function
REQ-008 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-009 IDLE: if any req_valid, select winner by round-robin starting at pointer rr_ptr; latch its write/baseaddr/nelems/wdata; pulse req_ready[winner] that same cycle; go ISSUE.
REQ-010 Winner requester SHALL hold its command stable only while req_valid is high and until req_ready; later changes are ignored.
REQ-011 Latched nelems == 0: skip bridge, go RESP with rsp_err=0, rsp_rdata unchanged.
REQ-012 Latched nelems > MAX_NELEMS: skip bridge, go RESP with rsp_err=1.
REQ-013 ISSUE: pulse sdr_readstart (read) or sdr_writestart (write) for exactly one cycle; go WAIT; clear timeout counter.
REQ-014 sdr_baseaddr, sdr_nelems, sdr_writedata SHALL equal latched values from ISSUE through WAIT and keep them in IDLE.
REQ-015 WAIT: matching end pulse (readend for read, writeend for write) -> RESP, rsp_err=0; non-matching end pulse ignored.
REQ-016 On sdr_readend for a read, capture sdr_readdata into rsp_rdata in that cycle.
REQ-017 WAIT timeout counter (21 bits, saturating) reaching TIMEOUT_CYC-1 without matching end -> RESP with rsp_err=1; end arriving on that same cycle wins (rsp_err=0).
REQ-018 RESP: pulse rsp_done[owner] one cycle with rsp_err valid; set rr_ptr = owner+1 modulo NREQ; return IDLE (next grant earliest the following cycle).
REQ-019 Latency: grant to start pulse 1 cycle; matching end to rsp_done 1 cycle.
REQ-020 busy SHALL be high in ISSUE, WAIT, RESP; low in IDLE.
REQ-021 req_valid deassertion by owner after grant SHALL not cancel the transaction.

Reset
REQ-022 sdr_reset_n low asynchronously forces IDLE; rr_ptr=0; all pulses, busy, rsp_err low; sdr_baseaddr, sdr_nelems 0; sdr_writedata, rsp_rdata 0; timeout counter 0.
REQ-023 Reset mid-transaction drops it silently; no rsp_done issued; late end pulses after reset are ignored in IDLE.

Structure
REQ-024 Shared package sdr_pkg: state enum, DATA_W, MAX_NELEMS, TIMEOUT_CYC defaults, command struct (write, baseaddr, nelems).
REQ-025 One sub-module rr_picker: combinational round-robin winner from req_valid and rr_ptr, outputs one-hot grant and index.

Verification
REQ-026 Single read: req 0 read base 0x0, nelems 15; bridge readend 10 cycles after start with data 0xDEAD.. -> start 1 cycle after ready, rsp_done[0] 1 cycle after end, rsp_rdata matches, rsp_err=0.
REQ-027 Contention: both valid continuously, rr_ptr=0 -> grants 0,1,0,1 alternate; no requester granted twice in a row.
REQ-028 Zero/oversize: nelems=0 -> no start pulse, rsp_done err=0; nelems=65 -> no start pulse, rsp_done err=1.
REQ-029 Timeout: TIMEOUT_CYC=16, no end pulse -> rsp_done with err=1 exactly 16 cycles after start pulse; end on cycle 16 -> err=0.
REQ-030 Wrong end: write in flight, readend pulsed -> ignored; writeend later completes normally, rsp_rdata unchanged.
REQ-031 Reset in WAIT: sdr_reset_n low 1 cycle -> outputs at reset values immediately, no rsp_done, subsequent readend ignored.
